// File: rtl/bus_pkg.sv
// Shared types and widths for the burst bus target: FSM state encoding and bus field widths.
package bus_pkg;

    localparam int DATA_W  = 32;
    localparam int BE_W    = 4;
    localparam int BURST_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_READ     = 2'd1,
        ST_READ_END = 2'd2,
        ST_WRITE    = 2'd3
    } state_t;

endpackage

// File: rtl/bus_responder_mem.sv
// Word-addressed register array, one 8-bit array per byte lane so each lane writes independently.
// Asynchronous read, synchronous byte-enabled write; contents are never reset.
module bus_responder_mem
    import bus_pkg::*;
#(
    parameter int ADDR_BITS = 6
) (
    input  logic                 i_clk,
    input  logic                 i_we,
    input  logic [BE_W-1:0]      i_be,
    input  logic [ADDR_BITS-1:0] i_waddr,
    input  logic [DATA_W-1:0]    i_wdata,
    input  logic [ADDR_BITS-1:0] i_raddr,
    output logic [DATA_W-1:0]    o_rdata
);

    generate
        for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
            logic [7:0] r_lane [2**ADDR_BITS];

            always_ff @(posedge i_clk) begin
                if (i_we && i_be[gi]) begin
                    r_lane[i_waddr] <= i_wdata[8*gi +: 8];
                end
            end

            assign o_rdata[8*gi +: 8] = r_lane[i_raddr];
        end
    endgenerate

endmodule

// File: rtl/bus_memory_responder.sv
// Bus target answering JTAG DMA bursts from a windowed register-array memory.
// Define BUS_RESPONDER_WAIT_STATE_EN to insert read gaps and alternating write busy cycles.
module bus_memory_responder
    import bus_pkg::*;
#(
    parameter int          ADDR_BITS    = 6,
    parameter logic [31:0] BASE_ADDRESS = 32'h5555_5500
) (
    input  logic               JTCK,
    input  logic               JRSTN,
    input  logic [DATA_W-1:0]  address_dataIN,
    input  logic [BE_W-1:0]    byte_enableIN,
    input  logic [BURST_W-1:0] burst_sizeIN,
    input  logic               read_n_writeIN,
    input  logic               begin_transactionIN,
    input  logic               end_transactionIN,
    input  logic               data_validIN,
    input  logic               busyIN,
    output logic [DATA_W-1:0]  address_dataOUT,
    output logic               data_validOUT,
    output logic               end_transactionOUT,
    output logic               busyOUT,
    output logic               errorOUT
);

    localparam int TAG_LSB = ADDR_BITS + 2;
    localparam int DEPTH   = 1 << ADDR_BITS;
    localparam int SUM_W   = ((ADDR_BITS > BURST_W) ? ADDR_BITS : BURST_W) + 1;

    state_t               r_state, w_state_next;
    logic [ADDR_BITS-1:0] r_idx, w_idx_next;
    logic [BURST_W:0]     r_count, w_count_next;
    logic [BE_W-1:0]      r_be, w_be_next;
    logic [DATA_W-1:0]    r_rdata, w_rdata_next;
    logic                 r_dvalid, w_dvalid_next;
    logic                 r_end, w_end_next;
    logic                 r_busy, w_busy_next;
    logic                 r_error, w_error_next;
    logic                 r_gap, w_gap_next;

    logic                 w_we;
    logic [ADDR_BITS-1:0] w_rd_idx;
    logic [DATA_W-1:0]    w_rd_data;
    logic [ADDR_BITS-1:0] w_begin_idx;
    logic [SUM_W-1:0]     w_sum;
    logic                 w_sel;
    logic                 w_range_err;

    assign w_begin_idx = address_dataIN[ADDR_BITS+1:2];
    assign w_sel       = begin_transactionIN && (r_state == ST_IDLE) &&
                         (address_dataIN[31:TAG_LSB] == BASE_ADDRESS[31:TAG_LSB]);
    // Widened sum so a burst running off the top of the array is rejected, never wrapped.
    assign w_sum       = SUM_W'(w_begin_idx) + SUM_W'(burst_sizeIN);
    assign w_range_err = w_sum > SUM_W'(DEPTH - 1);

    bus_responder_mem #(
        .ADDR_BITS (ADDR_BITS)
    ) u_mem (
        .i_clk   (JTCK),
        .i_we    (w_we),
        .i_be    (r_be),
        .i_waddr (r_idx),
        .i_wdata (address_dataIN),
        .i_raddr (w_rd_idx),
        .o_rdata (w_rd_data)
    );

    always_comb begin
        w_state_next  = r_state;
        w_idx_next    = r_idx;
        w_count_next  = r_count;
        w_be_next     = r_be;
        w_rdata_next  = r_rdata;
        w_dvalid_next = r_dvalid;
        w_end_next    = 1'b0;
        w_busy_next   = 1'b0;
        w_error_next  = 1'b0;
        w_gap_next    = r_gap;
        w_we          = 1'b0;
        w_rd_idx      = r_idx + ADDR_BITS'(1);

        case (r_state)
            ST_IDLE: begin
                w_rdata_next  = '0;
                w_dvalid_next = 1'b0;
                w_gap_next    = 1'b0;
                w_rd_idx      = w_begin_idx;
                if (w_sel) begin
                    if (w_range_err) begin
                        w_error_next = 1'b1;
                    end else begin
                        w_idx_next = w_begin_idx;
                        w_be_next  = byte_enableIN;
                        if (read_n_writeIN) begin
                            w_state_next  = ST_READ;
                            w_count_next  = {1'b0, burst_sizeIN};
                            w_rdata_next  = w_rd_data;
                            w_dvalid_next = 1'b1;
                        end else begin
                            // Write counts words still allowed, so extra beats are dropped.
                            w_state_next = ST_WRITE;
                            w_count_next = {1'b0, burst_sizeIN} + (BURST_W+1)'(1);
`ifdef BUS_RESPONDER_WAIT_STATE_EN
                            w_busy_next  = 1'b1;
`endif
                        end
                    end
                end
            end

            ST_READ: begin
                if (end_transactionIN) begin
                    w_state_next  = ST_IDLE;
                    w_rdata_next  = '0;
                    w_dvalid_next = 1'b0;
                    w_gap_next    = 1'b0;
                end else if (r_gap) begin
                    w_rd_idx      = r_idx;
                    w_rdata_next  = w_rd_data;
                    w_dvalid_next = 1'b1;
                    w_gap_next    = 1'b0;
                end else if (!busyIN) begin
                    if (r_count == '0) begin
                        w_state_next  = ST_READ_END;
                        w_rdata_next  = '0;
                        w_dvalid_next = 1'b0;
                        w_end_next    = 1'b1;
                    end else begin
                        w_idx_next   = r_idx + ADDR_BITS'(1);
                        w_count_next = r_count - (BURST_W+1)'(1);
`ifdef BUS_RESPONDER_WAIT_STATE_EN
                        w_rdata_next  = '0;
                        w_dvalid_next = 1'b0;
                        w_gap_next    = 1'b1;
`else
                        w_rdata_next  = w_rd_data;
                        w_dvalid_next = 1'b1;
`endif
                    end
                end
            end

            ST_READ_END: begin
                w_state_next = ST_IDLE;
            end

            ST_WRITE: begin
                if (data_validIN && !r_busy && (r_count != '0)) begin
                    w_we         = 1'b1;
                    w_idx_next   = r_idx + ADDR_BITS'(1);
                    w_count_next = r_count - (BURST_W+1)'(1);
                end
                if (end_transactionIN) begin
                    w_state_next = ST_IDLE;
                end else begin
`ifdef BUS_RESPONDER_WAIT_STATE_EN
                    w_busy_next = !r_busy;
`endif
                end
            end

            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge JTCK or negedge JRSTN) begin
        if (!JRSTN) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_count  <= '0;
            r_be     <= '0;
            r_rdata  <= '0;
            r_dvalid <= 1'b0;
            r_end    <= 1'b0;
            r_busy   <= 1'b0;
            r_error  <= 1'b0;
            r_gap    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_idx    <= w_idx_next;
            r_count  <= w_count_next;
            r_be     <= w_be_next;
            r_rdata  <= w_rdata_next;
            r_dvalid <= w_dvalid_next;
            r_end    <= w_end_next;
            r_busy   <= w_busy_next;
            r_error  <= w_error_next;
            r_gap    <= w_gap_next;
        end
    end

    assign address_dataOUT    = r_rdata;
    assign data_validOUT      = r_dvalid;
    assign end_transactionOUT = r_end;
    assign busyOUT            = r_busy;
    assign errorOUT           = r_error;

endmodule

// File: doc/bus_memory_responder.md
# bus_memory_responder

Bus-side target that answers the burst transactions issued by the JTAG DMA initiator (`jtag_support`). It is the other end of that protocol. The block decodes an address window and holds a word-addressed register-array memory. Write bursts are accepted with byte enables; read bursts are returned as data words followed by an end-of-transaction pulse. It sits on the shared bus next to other targets: when not selected, all of its outputs are 0 so they can be OR-combined.

## Interface
Parameters:
- `ADDR_BITS`, 6: memory depth is 2^ADDR_BITS 32-bit words.
- `BASE_ADDRESS`, 32'h5555_5500: window base. Must be aligned to 4·2^ADDR_BITS.

Ports:
- `JTCK` in 1: the single clock; everything is rising-edge.
- `JRSTN` in 1: reset, asynchronous, active-low.
- `address_dataIN` in 32: address during begin, write data during a write burst.
- `byte_enableIN` in 4: byte lanes, sampled at begin.
- `burst_sizeIN` in 8: burst length minus 1, sampled at begin.
- `read_n_writeIN` in 1: 1 = read, sampled at begin.
- `begin_transactionIN` in 1: one-cycle transaction start.
- `end_transactionIN` in 1: initiator ends a write, or aborts a read.
- `data_validIN` in 1: write data is valid.
- `busyIN` in 1: initiator stall during a read.
- `address_dataOUT` out 32: read data.
- `data_validOUT` out 1: read data is valid.
- `end_transactionOUT` out 1: one-cycle pulse closing a read burst.
- `busyOUT` out 1: target stall during a write.
- `errorOUT` out 1: one-cycle pulse on a rejected transaction.

## Operation
- **States:** IDLE, READ, READ_END, WRITE.
- **Selection:** `begin_transactionIN` is high in IDLE and `address_dataIN[31:ADDR_BITS+2]` equals `BASE_ADDRESS[31:ADDR_BITS+2]`.
  - Latch word index `idx = address_dataIN[ADDR_BITS+1:2]`, `remaining = burst_sizeIN`, byte enables and direction.
  - Address bits [1:0] are ignored.
- **Not selected:** no state change; all outputs stay 0.
- **Range check:** if `idx + burst_sizeIN > 2^ADDR_BITS-1` (9-bit sum, no wrap), pulse `errorOUT` and remain in IDLE. No memory access. No wrap-around ever occurs.
- **READ:** each cycle with `busyIN`=0, drive `address_dataOUT = mem[idx]` and `data_validOUT = 1`, then increment `idx` and decrement `remaining`.
  - With `busyIN`=1, the presented word and `data_validOUT` are held unchanged.
  - After the word with `remaining`==0 is accepted, go to READ_END.
- **READ_END:** `end_transactionOUT` = 1 and `data_validOUT` = 0 for one cycle, then IDLE.
- **WRITE:** each cycle with `data_validIN`=1 and `busyOUT`=0, write `address_dataIN` into `mem[idx]` on the lanes where the latched `byte_enable` is 1. Then increment `idx`.
  - Words beyond burst_size+1 are ignored.
  - `end_transactionIN` returns to IDLE. A simultaneous final `data_validIN` word is still written.
- **Abort:** `end_transactionIN` in READ goes to IDLE, with outputs 0 from the next cycle. No `end_transactionOUT` is issued.
- **Begin while busy:** `begin_transactionIN` outside IDLE is ignored.
- **Reset:** asynchronous, any state → IDLE, all outputs 0, counters 0. Memory contents are not reset.

## Timing
- Begin sampled at edge T:
  - First read word is valid in cycle T+1.
  - `errorOUT` is high in cycle T+1.
  - Write data is accepted from cycle T+1.
- Read burst of N words with no stalls: `data_validOUT` high T+1…T+N, `end_transactionOUT` high at T+N+1.
- Outputs are registered. Memory read is combinational from the register array.
- Reset values: `address_dataOUT`=0, `data_validOUT`=0, `end_transactionOUT`=0, `busyOUT`=0, `errorOUT`=0.

## Configuration
- `BUS_RESPONDER_WAIT_STATE_EN` defined: insert wait states.
  - READ: a one-cycle gap with `data_validOUT`=0 after every word.
  - WRITE: `busyOUT` alternates 1,0,1,0…, starting at 1 in T+1. Words are accepted only on 0 cycles.
- Undefined: zero wait states. `busyOUT` is constantly 0.

## Structure
- Shared package `bus_pkg`:
  - state enum.
  - widths: DATA_W=32, BE_W=4, BURST_W=8.
- One sub-module, `bus_responder_mem`: the byte-lane-writable register array, with async read and sync write.
- The FSM and window decode stay in the top.

## Test plan
- **Single write then read:** write 32'hDEADBEEF at 32'h5555_5500 with BE 1111 and burst 0, then read it back. Expect `address_dataOUT`=DEADBEEF at T+1 and `end_transactionOUT` at T+2.
- **Byte-enable write:** write 32'h12345678 over DEADBEEF with BE 0011. The read returns DEAD5678.
- **Read with initiator stall:** 4-word burst read, `busyIN` high for 3 cycles on word 2. Word 2 is held stable; 4 valids total; `end_transactionOUT` one cycle after the last word.
- **Out-of-window begin:** address 32'h1000_0000. All outputs stay 0 and memory is unchanged.
- **Range error:** begin at the last word with burst 1. `errorOUT` pulses at T+1, no data, back in IDLE.
- **Reset mid-burst:** `JRSTN` low during a read. Outputs go to 0 immediately; the next in-window begin is served normally. With `BUS_RESPONDER_WAIT_STATE_EN`, rerun the write test and check alternating `busyOUT`.
